// File: rtl/alu_dispatch.sv
// Issue-side ALU dispatcher: accepts one op, issues it to one of four lanes, waits for the
// lane to finish, then presents the result-mux selector until the consumer takes the result.
module alu_dispatch #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [2:0]        op_code_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic [3:0]        lane_valid_o,
  input  logic [3:0]        lane_ready_i,
  output logic [DATA_W-1:0] lane_a_o,
  output logic [DATA_W-1:0] lane_b_o,
  input  logic [3:0]        lane_done_i,
  output logic [2:0]        sel_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              err_valid_o,
  output logic [1:0]        err_code_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StErr} state_e;

  state_e              state_q;
  logic [3:0]          lane_valid_q;
  logic [DATA_W-1:0]   lane_a_q, lane_b_q;
  logic [2:0]          sel_q;
  logic                res_valid_q;
  logic                err_valid_q;
  logic [1:0]          err_code_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     cnt_d;

  // Saturating increment: the counter never wraps back past TIMEOUT.
  always_comb begin
    cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      lane_valid_q <= '0;
      lane_a_q     <= '0;
      lane_b_q     <= '0;
      sel_q        <= '0;
      res_valid_q  <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (op_valid_i) begin
            if (op_code_i[2]) begin
              // Illegal op: operands and selector keep the previous op's values.
              state_q     <= StErr;
              err_valid_q <= 1'b1;
              err_code_q  <= 2'b01;
            end else begin
              state_q      <= StIssue;
              lane_a_q     <= op_a_i;
              lane_b_q     <= op_b_i;
              sel_q        <= {1'b0, op_code_i[1:0]};
              lane_valid_q <= 4'b0001 << op_code_i[1:0];
            end
          end
        end
        StIssue: begin
          if (lane_ready_i[sel_q[1:0]]) begin
            state_q      <= StWait;
            lane_valid_q <= '0;
            cnt_q        <= '0;
          end
        end
        StWait: begin
          cnt_q <= cnt_d;
          // Done takes priority over a timeout firing in the same cycle.
          if (lane_done_i[sel_q[1:0]]) begin
            state_q     <= StDone;
            res_valid_q <= 1'b1;
          end else if (cnt_q == CntLast) begin
            state_q     <= StErr;
            err_valid_q <= 1'b1;
            err_code_q  <= 2'b10;
          end
        end
        StDone: begin
          if (res_ready_i) begin
            state_q     <= StIdle;
            res_valid_q <= 1'b0;
          end
        end
        StErr: begin
          state_q     <= StIdle;
          err_valid_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign op_ready_o   = (state_q == StIdle);
  assign lane_valid_o = lane_valid_q;
  assign lane_a_o     = lane_a_q;
  assign lane_b_o     = lane_b_q;
  assign sel_o        = sel_q;
  assign res_valid_o  = res_valid_q;
  assign err_valid_o  = err_valid_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: per-op latency, stalls, illegal op, timeout and reset cases.
module tb_alu_dispatch;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [DATA_W-1:0] op_a, op_b;
  logic [3:0]        lane_valid, lane_ready, lane_done;
  logic [DATA_W-1:0] lane_a, lane_b;
  logic [2:0]        sel;
  logic              res_valid, res_ready, err_valid;
  logic [1:0]        err_code;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  alu_dispatch #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .op_valid_i   (op_valid),
    .op_ready_o   (op_ready),
    .op_code_i    (op_code),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .lane_valid_o (lane_valid),
    .lane_ready_i (lane_ready),
    .lane_a_o     (lane_a),
    .lane_b_o     (lane_b),
    .lane_done_i  (lane_done),
    .sel_o        (sel),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .err_valid_o  (err_valid),
    .err_code_o   (err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Best-case op: lanes ready at once, done in the first WAIT cycle, one res_ready stall cycle.
  task automatic run_op(input logic [2:0] code, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b);
    logic [3:0] oh;
    oh = 4'b0001 << code[1:0];
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b; lane_ready = 4'hF;
    step();
    op_valid = 1'b0;
    check("op_lane_valid", 32'(lane_valid), 32'(oh));
    check("op_sel", 32'(sel), 32'(code));
    check("op_lane_a", 32'(lane_a), 32'(a));
    check("op_lane_b", 32'(lane_b), 32'(b));
    check("op_ready_busy", 32'(op_ready), 32'd0);
    step();
    check("op_wait_lane_valid", 32'(lane_valid), 32'd0);
    check("op_wait_res_valid", 32'(res_valid), 32'd0);
    lane_done = oh;
    step();
    lane_done = 4'b0;
    check("op_res_valid", 32'(res_valid), 32'd1);
    step();
    check("op_res_hold", 32'(res_valid), 32'd1);
    check("op_sel_hold", 32'(sel), 32'(code));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("op_res_drop", 32'(res_valid), 32'd0);
    check("op_ready_back", 32'(op_ready), 32'd1);
  endtask

  // Issue an op and step into its first WAIT cycle.
  task automatic enter_wait(input logic [2:0] code);
    op_valid = 1'b1; op_code = code; op_a = 24'hABCDEF; op_b = 24'h000123; lane_ready = 4'hF;
    step();
    op_valid = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b1; op_code = 3'b010; op_a = 24'h55AA55; op_b = 24'h0F0F0F;
    lane_ready = 4'hF; lane_done = 4'h0; res_ready = 1'b0;
    step();
    step();
    op_valid = 1'b0;
    rst_n = 1'b1;
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_lane_valid", 32'(lane_valid), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_lane_a", 32'(lane_a), 32'd0);
    check("rst_lane_b", 32'(lane_b), 32'd0);
    step();
    check("rst_idle_after", 32'(op_ready), 32'd1);

    run_op(3'b010, 24'h00000F, 24'h000001);
    run_op(3'b000, 24'hF0F0F0, 24'h0FF00F);
    run_op(3'b001, 24'h123456, 24'h654321);
    run_op(3'b011, 24'hFFFFFF, 24'h000000);

    // Stall: lane 1 not ready for 5 cycles, other lanes ready (must be ignored).
    op_valid = 1'b1; op_code = 3'b001; op_a = 24'h00C0DE; op_b = 24'h00BEEF;
    lane_ready = 4'b1101;
    step();
    op_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      check("stall_lane_valid", 32'(lane_valid), 32'b0010);
      if (i == 6) lane_ready = 4'hF;
      step();
    end
    check("stall_wait", 32'(lane_valid), 32'd0);
    lane_done = 4'b0010;
    step();
    lane_done = 4'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_sel", 32'(sel), 32'b001);
      step();
    end
    res_ready = 1'b1;
    check("stall_res_last", 32'(res_valid), 32'd1);
    step();
    res_ready = 1'b0;
    check("stall_res_drop", 32'(res_valid), 32'd0);

    // Illegal opcode: previous op's selector and operands stay.
    op_valid = 1'b1; op_code = 3'b101; op_a = 24'h111111; op_b = 24'h222222;
    step();
    op_valid = 1'b0;
    check("ill_err_valid", 32'(err_valid), 32'd1);
    check("ill_err_code", 32'(err_code), 32'b01);
    check("ill_lane_valid", 32'(lane_valid), 32'd0);
    check("ill_sel", 32'(sel), 32'b001);
    check("ill_lane_a", 32'(lane_a), 32'h00C0DE);
    check("ill_op_ready", 32'(op_ready), 32'd0);
    step();
    check("ill_err_drop", 32'(err_valid), 32'd0);
    check("ill_code_hold", 32'(err_code), 32'b01);
    check("ill_ready_back", 32'(op_ready), 32'd1);

    // Timeout on LESS with a spurious done on lane 0.
    enter_wait(3'b011);
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      check("to_no_err", 32'(err_valid), 32'd0);
      check("to_no_res", 32'(res_valid), 32'd0);
      lane_done = (k == 3) ? 4'b0001 : 4'b0000;
      step();
    end
    lane_done = 4'b0;
    check("to_err_valid", 32'(err_valid), 32'd1);
    check("to_err_code", 32'(err_code), 32'b10);
    check("to_res_valid", 32'(res_valid), 32'd0);
    step();
    check("to_err_drop", 32'(err_valid), 32'd0);
    check("to_code_hold", 32'(err_code), 32'b10);
    check("to_ready_back", 32'(op_ready), 32'd1);

    // Done in the last WAIT cycle wins over the timeout.
    enter_wait(3'b010);
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      lane_done = (k == int'(TIMEOUT) - 1) ? 4'b0100 : 4'b0000;
      step();
    end
    lane_done = 4'b0;
    check("bnd_res_valid", 32'(res_valid), 32'd1);
    check("bnd_no_err", 32'(err_valid), 32'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("bnd_idle", 32'(op_ready), 32'd1);

    // Reset during WAIT, then a late done must be ignored.
    enter_wait(3'b000);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_ready", 32'(op_ready), 32'd1);
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_lane_a", 32'(lane_a), 32'd0);
    check("mid_rst_err_code", 32'(err_code), 32'd0);
    lane_done = 4'b0001;
    step();
    lane_done = 4'b0;
    check("late_done_res", 32'(res_valid), 32'd0);
    check("late_done_ready", 32'(op_ready), 32'd1);
    step();
    check("late_done_res2", 32'(res_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Issue-side counterpart of the ALU result multiplexer. It accepts one ALU operation at a time over a valid/ready handshake and routes the 24-bit operands to one of four functional-unit lanes: AND, OR, Adder or LESS. It waits for that lane to finish, then drives the 3-bit result selector to the 4:1 result mux and holds it stable until the consumer takes the result. Illegal opcodes and hung lanes are reported on an error strobe rather than stalling the datapath.

## Interface
- DATA_W, 24: operand width.
- TIMEOUT, 15: maximum cycles spent in WAIT before a timeout error; legal range 1..255.

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- op_valid  in  1  upstream operation valid
- op_ready  out  1  dispatcher can accept an operation
- op_code  in  3  000 AND, 001 OR, 010 ADD, 011 LESS, 1xx illegal
- op_a, op_b  in  DATA_W  operands
- lane_valid  out  4  one-hot issue strobe, bit i = lane i
- lane_ready  in  4  lane i accepts issue
- lane_a, lane_b  out  DATA_W  registered operands, shared by all lanes
- lane_done  in  4  lane i result ready (single-cycle pulse)
- sel  out  3  result-mux selector, same encoding as op_code
- res_valid  out  1  result on mux output is valid under sel
- res_ready  in  1  consumer takes the result
- err_valid  out  1  one-cycle error strobe
- err_code  out  2  01 illegal opcode, 10 timeout, 00 none

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- **IDLE**
  - op_ready=1; all other strobes are 0.
  - On op_valid: latch op_a/op_b into lane_a/lane_b and op_code[1:0] into sel (sel[2]=0).
  - Legal op_code goes to ISSUE; op_code[2]=1 goes to ERR with err_code=01. sel and lanes are unchanged on an illegal op.
- **ISSUE**
  - lane_valid = one-hot(sel).
  - Stays in ISSUE until lane_ready[sel]=1, then goes to WAIT with the timeout counter cleared.
  - lane_ready bits of other lanes are ignored.
- **WAIT**
  - lane_valid=0; the counter increments each cycle.
  - lane_done[sel]=1 goes to DONE.
  - Counter reaching TIMEOUT with no done goes to ERR with err_code=10.
  - lane_done on other lanes is ignored.
  - If done and the timeout fire in the same cycle, done wins.
- **DONE**
  - res_valid=1; sel is held.
  - res_ready=1 returns to IDLE. res_valid drops the following cycle.
- **ERR**
  - err_valid=1 for exactly one cycle, then IDLE.
  - err_code holds its value until the next error or reset.
- **Invariants**
  - op_ready is 1 only in IDLE, so there is no back-to-back accept.
  - lane_a, lane_b and sel change only on an IDLE accept.
  - At most one lane_valid bit is ever set.
- **Reset** (rst_n=0 sampled at clk): state=IDLE, op_ready=1 from the next cycle, and lane_valid, res_valid, err_valid, err_code, sel, lane_a, lane_b and the counter are all 0.
  - Reset mid-operation abandons the in-flight op.
  - A lane_done arriving after reset is ignored.

## Timing
- All outputs are registered except op_ready, which decodes state == IDLE.
- Best-case latency, accept at edge 0:
  - lane_valid high in cycle 1.
  - With lane_ready=1 in cycle 1, WAIT in cycle 2.
  - With lane_done in cycle 2, res_valid in cycle 3.
- Accept-to-res_valid is therefore 3 cycles minimum.
- With res_ready=1 in cycle 3, the next op can be accepted in cycle 4, giving a throughput of one op per 4 cycles.
- Timeout: ERR is entered TIMEOUT cycles after entering WAIT, and err_valid is seen on the next cycle.
- Illegal opcode: err_valid is high in cycle 1 and op_ready returns in cycle 2.
- The TIMEOUT counter is $clog2(TIMEOUT+1) bits wide and saturates (never wraps).

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles while op_valid=1 -> no accept; all outputs 0 and op_ready=1 after release.
- **ADD:** op_code=010, op_a=24'h00000F, op_b=24'h000001; lanes ready immediately; lane_done[2] in the cycle after issue -> lane_valid=4'b0100 in cycle 1, res_valid in cycle 3, sel=3'b010 held until res_ready. Repeat for 000, 001 and 011 with sel matching.
- **Stall:** lane_ready[1]=0 for 5 cycles, op OR -> lane_valid=4'b0010 held for 6 cycles; res_ready=0 for 3 cycles -> res_valid and sel stable for those cycles.
- **Illegal opcode:** op_code=3'b101 -> accepted, err_valid pulse with err_code=01, no lane_valid, sel unchanged from the previous op.
- **Timeout and spurious done:** op LESS, pulse lane_done[0] during WAIT, never pulse lane_done[3] -> spurious done ignored; err_code=10 and err_valid 1 cycle after TIMEOUT=15 WAIT cycles.
- **Boundary:** lane_done[sel] in the same cycle the counter hits TIMEOUT -> DONE, no error; rst_n=0 during WAIT -> IDLE next cycle, and a late lane_done produces no res_valid.
